// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared state/select encodings, 1024x768 timing defaults and counter helpers
package vga_mon_pkg;
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;
  typedef enum logic [1:0] {
    SEL_HTOT   = 2'd0,
    SEL_HSYNC  = 2'd1,
    SEL_VTOT   = 2'd2,
    SEL_STATUS = 2'd3
  } sel_t;
  localparam int DEF_H_TOTAL = 1344;
  localparam int DEF_H_SYNC  = 136;
  localparam int DEF_V_TOTAL = 806;
  localparam int DEF_V_SYNC  = 6;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
  function automatic logic in_tol(input logic [15:0] v, input int exp, input int tol);
    return int'(v) >= exp - tol && int'(v) <= exp + tol;
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchroniser, polarity correction and registered rise/fall pulses
module sync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic active,
  output logic rise,
  output logic fall
);
  logic s1, s2, act;
  assign act = s2 ~^ POL;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ~POL;
      s2 <= ~POL;
      active <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      active <= act;
      rise <= act & ~active;
      fall <= ~act & active;
    end
  end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: measures TinyVGA sync timing and tracks lock against an expected video mode
module vga_timing_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int V_TOTAL = DEF_V_TOTAL,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int TOL = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pmod_in,
  input  logic [1:0]  sel,
  output logic [15:0] meas,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic        frame_tick
);
  logic hs_act, hs_rise, hs_fall, vs_act, vs_rise, vs_fall;
  logic [15:0] hcnt, hwcnt, lcnt, vwcnt, cur_htot, cur_hsw;
  logic [15:0] meas_htot, meas_hsw, meas_vtot, meas_vsw;
  logic [15:0] htot_now, hsw_now, lcnt_now, vw_now, meas_src;
  logic [7:0] good_run, good_run_nx, err_nx;
  logic frame_good, timeout, unused;
  mon_state_t state, state_nx;
  sync_edge_detect #(.POL(HS_POL)) u_hs (
    .clk(clk), .rst(rst), .pin(pmod_in[7]), .active(hs_act), .rise(hs_rise), .fall(hs_fall)
  );
  sync_edge_detect #(.POL(VS_POL)) u_vs (
    .clk(clk), .rst(rst), .pin(pmod_in[3]), .active(vs_act), .rise(vs_rise), .fall(vs_fall)
  );
  assign unused = ^{pmod_in[6:4], pmod_in[2:0], vs_fall, meas_vsw};
  assign htot_now = hs_rise ? sat_inc(hcnt) : cur_htot;
  assign hsw_now = hs_fall ? hwcnt : cur_hsw;
  assign lcnt_now = hs_rise ? sat_inc(lcnt) : lcnt;
  assign vw_now = hs_rise && vs_act ? sat_inc(vwcnt) : vwcnt;
  assign frame_good = in_tol(htot_now, H_TOTAL, TOL) && in_tol(hsw_now, H_SYNC, TOL) &&
                      lcnt_now == 16'(V_TOTAL) && vw_now == 16'(V_SYNC) &&
                      !(&htot_now || &hsw_now || &lcnt_now || &vw_now);
  assign timeout = state != SEARCH && lcnt >= 16'(2 * V_TOTAL);
  assign locked = state == LOCKED;
  assign meas_src = sel == SEL_HTOT  ? meas_htot :
                    sel == SEL_HSYNC ? meas_hsw  :
                    sel == SEL_VTOT  ? meas_vtot : {err_count, state, 6'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      hwcnt <= '0;
      lcnt <= '0;
      vwcnt <= '0;
      cur_htot <= '0;
      cur_hsw <= '0;
      meas_htot <= '0;
      meas_hsw <= '0;
      meas_vtot <= '0;
      meas_vsw <= '0;
      frame_tick <= 1'b0;
      meas <= '0;
    end else begin
      hcnt <= hs_rise ? '0 : sat_inc(hcnt);
      hwcnt <= hs_fall ? '0 : hs_act ? sat_inc(hwcnt) : hwcnt;
      cur_htot <= htot_now;
      cur_hsw <= hsw_now;
      lcnt <= vs_rise ? '0 : lcnt_now;
      vwcnt <= vs_rise ? '0 : vw_now;
      meas_htot <= vs_rise ? htot_now : meas_htot;
      meas_hsw <= vs_rise ? hsw_now : meas_hsw;
      meas_vtot <= vs_rise ? lcnt_now : meas_vtot;
      meas_vsw <= vs_rise ? vw_now : meas_vsw;
      frame_tick <= vs_rise;
      meas <= meas_src;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
      good_run <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      good_run <= good_run_nx;
      err_count <= err_nx;
    end
  end
  always_comb begin
    state_nx = state;
    good_run_nx = good_run;
    err_nx = err_count;
    if (vs_rise && state == SEARCH) begin
      state_nx = ACQUIRE;
      good_run_nx = '0;
    end else if (vs_rise && frame_good) begin
      good_run_nx = state == ACQUIRE ? good_run + 8'd1 : good_run;
      state_nx = state == ACQUIRE && good_run_nx >= 8'(LOCK_FRAMES) ? LOCKED : state;
    end else if (vs_rise) begin
      good_run_nx = '0;
      state_nx = ACQUIRE;
      err_nx = state == LOCKED && !(&err_count) ? err_count + 8'd1 : err_count;
    end else if (timeout) begin
      state_nx = SEARCH;
      good_run_nx = '0;
    end
  end
endmodule
